// File: rtl/serial_transmitter.sv
// rtl/serial_transmitter.sv - byte-to-serial frame transmitter (start, 8 data LSB-first, optional parity, stop)
module serial_transmitter #(
  parameter int BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] word_in,
  input  logic [1:0] F,
  output logic       data,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] TICK_LAST = 8'(BIT_CLKS - 1);

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] mode_q, mode_d;
  logic       data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       parity_en;
  logic       parity_bit;

  assign bit_end    = (tick_q == TICK_LAST);
  assign parity_en  = (mode_q == 2'b01) || (mode_q == 2'b10);
  // mode 01 is even parity (XOR), mode 10 odd (XNOR); taken from the untouched latched byte
  assign parity_bit = mode_q[0] ? ^byte_q : ~^byte_q;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    mode_d  = mode_q;
    if (en) begin
      if (state_q == IDLE) begin
        if (load) begin
          shift_d = word_in;
          byte_d  = word_in;
          mode_d  = F;
          tick_d  = 8'd0;
          idx_d   = 3'd0;
          state_d = START;
        end
      end else begin
        tick_d = bit_end ? 8'd0 : tick_q + 8'd1;
        if (bit_end) begin
          case (state_q)
            START: begin
              state_d = DATA;
              idx_d   = 3'd0;
            end
            DATA: begin
              shift_d = {1'b0, shift_q[7:1]};
              idx_d   = idx_q + 3'd1;
              if (idx_q == 3'd7) state_d = parity_en ? PARITY : STOP;
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  // Registered outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    data_d = 1'b1;
    case (state_d)
      START:   data_d = 1'b0;
      DATA:    data_d = shift_d[0];
      PARITY:  data_d = parity_bit;
      default: data_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tick_d == TICK_LAST);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
      byte_q  <= 8'd0;
      mode_q  <= 2'b00;
      data_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_serial_transmitter.sv
// tb/tb_serial_transmitter.sv - scoreboard bench for serial_transmitter
module tb_serial_transmitter;

  localparam int BC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b1;
  logic       load = 1'b0;
  logic [7:0] word_in = 8'h00;
  logic [1:0] F = 2'b00;
  logic       data, ready, busy, done;

  int pass_cnt = 0;
  int check_cnt = 0;
  int fail_cnt = 0;

  // each entry is {data, busy, done, ready} expected for one clock
  logic [3:0] exp_q[$];

  serial_transmitter #(.BIT_CLKS(BC)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .word_in(word_in),
    .F(F), .data(data), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_bit(input logic b, input int n, input bit last_done);
    for (int i = 0; i < n; i++)
      exp_q.push_back({b, 1'b1, (last_done && i == n - 1) ? 1'b1 : 1'b0, 1'b0});
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(4'b1001);
  endfunction

  function automatic void push_frame(input logic [7:0] b, input logic [1:0] f, input int start_extra);
    logic p;
    p = (f == 2'b01) ? ^b : ~^b;
    push_bit(1'b0, BC + start_extra, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(b[i], BC, 1'b0);
    if (f == 2'b01 || f == 2'b10) push_bit(p, BC, 1'b0);
    push_bit(1'b1, BC, 1'b1);
  endfunction

  task automatic start_frame(input logic [7:0] b, input logic [1:0] f, input bit keep);
    @(posedge clk); #1;
    load = 1'b1;
    word_in = b;
    F = f;
    @(posedge clk); #1;
    if (!keep) begin
      load = 1'b0;
      word_in = 8'($urandom);
      F = 2'($urandom);
    end
  endtask

  // ev_kind: 0 none, 1 load a new word mid-frame, 2 drop en for 5 clocks, 3 release load
  task automatic check_cycles(input string tag, input int ev_at, input int ev_kind, input int n_lim);
    int n;
    logic [3:0] e;
    n = (n_lim >= 0) ? n_lim : exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, i), {28'd0, data, busy, done, ready}, {28'd0, e});
      if (i == ev_at) begin
        case (ev_kind)
          1: begin load = 1'b1; word_in = 8'hFF; F = 2'b01; end
          2: en = 1'b0;
          3: load = 1'b0;
          default: ;
        endcase
      end
      if (ev_kind == 1 && i == ev_at + 10) load = 1'b0;
      if (ev_kind == 2 && i == ev_at + 5) en = 1'b1;
    end
    if (n_lim >= 0) exp_q.delete();
  endtask

  initial begin
    load = 1'b1;
    word_in = 8'h12;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", {31'd0, data}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);

    reset = 1'b1;
    en = 1'b0;
    push_idle(5);
    check_cycles("en_low_load", -1, 0, -1);
    load = 1'b0;
    en = 1'b1;
    push_idle(100);
    check_cycles("idle", -1, 0, -1);

    start_frame(8'hA5, 2'b00, 1'b0);
    push_frame(8'hA5, 2'b00, 0); push_idle(2);
    check_cycles("a5_none", -1, 0, -1);

    start_frame(8'hA5, 2'b01, 1'b0);
    push_frame(8'hA5, 2'b01, 0); push_idle(2);
    check_cycles("a5_even", -1, 0, -1);

    start_frame(8'hA5, 2'b10, 1'b0);
    push_frame(8'hA5, 2'b10, 0); push_idle(2);
    check_cycles("a5_odd", -1, 0, -1);

    start_frame(8'h07, 2'b01, 1'b0);
    push_frame(8'h07, 2'b01, 0); push_idle(2);
    check_cycles("07_even", -1, 0, -1);

    start_frame(8'h07, 2'b11, 1'b0);
    push_frame(8'h07, 2'b11, 0); push_idle(2);
    check_cycles("07_rsvd", -1, 0, -1);

    start_frame(8'h5A, 2'b00, 1'b0);
    push_frame(8'h5A, 2'b00, 0); push_idle(2);
    check_cycles("disturb", 50, 1, -1);

    start_frame(8'h3C, 2'b00, 1'b1);
    word_in = 8'hC3;
    push_frame(8'h3C, 2'b00, 0); push_idle(1);
    push_frame(8'hC3, 2'b00, 0); push_idle(2);
    check_cycles("b2b", 170, 3, -1);

    start_frame(8'h81, 2'b01, 1'b0);
    push_frame(8'h81, 2'b01, 5); push_idle(2);
    check_cycles("en_drop", 3, 2, -1);

    start_frame(8'hA5, 2'b00, 1'b0);
    push_frame(8'hA5, 2'b00, 0);
    check_cycles("pre_rst", -1, 0, 86);
    reset = 1'b0;
    push_idle(1);
    check_cycles("mid_rst", -1, 0, -1);
    reset = 1'b1;
    push_idle(200);
    check_cycles("post_rst", -1, 0, -1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
